// File: rtl/custom_prescaler_bank.sv
// Bank of NUM_CH programmable down-counting prescalers, each emitting a one-cycle tick,
// configured and observed over a single Avalon-MM slave.
module custom_prescaler_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 28,
    parameter int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [31:0]       avs_s0_writedata,
    output logic [31:0]       avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    output logic [NUM_CH-1:0] tick,
    output logic              irq
);

    logic [CNT_W-1:0]  r_reload [NUM_CH];
    logic [CNT_W-1:0]  r_count  [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_oneshot;
    logic [NUM_CH-1:0] r_flag;
    logic [NUM_CH-1:0] r_irq_en;
    logic [NUM_CH-1:0] r_tick;
    logic              r_irq;
    logic [31:0]       r_rdata;
    logic              r_rvalid;

    logic [31:0]       w_ch;
    logic [1:0]        w_reg;
    logic [NUM_CH-1:0] w_wr_reload;
    logic [NUM_CH-1:0] w_wr_ctrl;
    logic [NUM_CH-1:0] w_term;
    logic [31:0]       w_rdata;

    assign w_ch  = 32'(avs_s0_address) >> 2;
    assign w_reg = avs_s0_address[1:0];

    // Out-of-range channel indices match no channel, so they read 0 and writes fall away.
    always_comb begin
        w_wr_reload = '0;
        w_wr_ctrl   = '0;
        w_term      = '0;
        w_rdata     = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_ch == c) begin
                w_wr_reload[c] = avs_s0_write && (w_reg == 2'd0);
                w_wr_ctrl[c]   = avs_s0_write && (w_reg == 2'd1);
                case (w_reg)
                    2'd0:    w_rdata = 32'(r_reload[c]);
                    2'd1:    w_rdata = {28'd0, r_irq_en[c], r_flag[c], r_oneshot[c], r_en[c]};
                    2'd2:    w_rdata = 32'(r_count[c]);
                    default: w_rdata = '0;
                endcase
            end
            // A reload write pre-empts the terminal event entirely (no tick, flag or one-shot stop).
            w_term[c] = r_en[c] && (r_count[c] == '0) && !w_wr_reload[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                r_reload[c] <= '1;
                r_count[c]  <= '1;
            end
            r_en      <= '0;
            r_oneshot <= '0;
            r_flag    <= '0;
            r_irq_en  <= '0;
            r_tick    <= '0;
            r_irq     <= 1'b0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (w_wr_reload[c]) begin
                    r_reload[c] <= avs_s0_writedata[CNT_W-1:0];
                    r_count[c]  <= avs_s0_writedata[CNT_W-1:0];
                    r_tick[c]   <= 1'b0;
                end else begin
                    r_tick[c] <= w_term[c];
                    if (w_term[c] || (w_wr_ctrl[c] && avs_s0_writedata[0] && !r_en[c]))
                        r_count[c] <= r_reload[c];
                    else if (r_en[c])
                        r_count[c] <= r_count[c] - CNT_W'(1);
                end

                // A CTRL write overrides the one-shot auto-disable in the same cycle.
                if (w_wr_ctrl[c]) begin
                    r_en[c]      <= avs_s0_writedata[0];
                    r_oneshot[c] <= avs_s0_writedata[1];
                    r_irq_en[c]  <= avs_s0_writedata[3];
                end else if (w_term[c] && r_oneshot[c]) begin
                    r_en[c] <= 1'b0;
                end

                if (w_term[c])
                    r_flag[c] <= 1'b1;
                else if (w_wr_ctrl[c] && avs_s0_writedata[2])
                    r_flag[c] <= 1'b0;
            end

            r_irq    <= |(r_flag & r_irq_en);
            r_rvalid <= avs_s0_read;
            if (avs_s0_read)
                r_rdata <= w_rdata;
        end
    end

    assign avs_s0_readdata      = r_rdata;
    assign avs_s0_readdatavalid = r_rvalid;
    assign tick                 = r_tick;
    assign irq                  = r_irq;

endmodule

// File: tb/tb_custom_prescaler_bank.sv
// Directed bench for custom_prescaler_bank: default 4-channel instance plus a 3-channel
// instance for out-of-range channel decoding.
module tb_custom_prescaler_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [3:0]  tick;
    logic        irq;

    logic [3:0]  b_address;
    logic        b_read;
    logic        b_write;
    logic [31:0] b_writedata;
    logic [31:0] b_readdata;
    logic        b_readdatavalid;
    logic [2:0]  b_tick;
    logic        b_irq;

    int n_total = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    custom_prescaler_bank #(.NUM_CH(4), .CNT_W(28)) dut (
        .clk(clk), .reset(reset),
        .avs_s0_address(address), .avs_s0_read(read), .avs_s0_write(write),
        .avs_s0_writedata(writedata), .avs_s0_readdata(readdata),
        .avs_s0_readdatavalid(readdatavalid), .tick(tick), .irq(irq)
    );

    custom_prescaler_bank #(.NUM_CH(3), .CNT_W(28)) dut3 (
        .clk(clk), .reset(reset),
        .avs_s0_address(b_address), .avs_s0_read(b_read), .avs_s0_write(b_write),
        .avs_s0_writedata(b_writedata), .avs_s0_readdata(b_readdata),
        .avs_s0_readdatavalid(b_readdatavalid), .tick(b_tick), .irq(b_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        step(1);
        write     = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        address = a;
        read    = 1'b1;
        step(1);
        read    = 1'b0;
        chk({tag, "_valid"}, 32'(readdatavalid), 32'd1);
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        b_address = '0; b_read = 1'b0; b_write = 1'b0; b_writedata = '0;
        step(2);
        reset = 1'b0;
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rvalid", 32'(readdatavalid), 32'h0);
        chk("rst_rdata", readdata, 32'h0);

        // Reset values on ch0
        do_read(4'd0, 32'h0FFF_FFFF, "ch0_reload_rst");
        step(1);
        chk("rvalid_drop", 32'(readdatavalid), 32'h0);
        chk("rdata_hold", readdata, 32'h0FFF_FFFF);
        do_read(4'd1, 32'h0, "ch0_ctrl_rst");
        do_read(4'd2, 32'h0FFF_FFFF, "ch0_count_rst");

        // Simultaneous read+write on ch3 RELOAD: read sees pre-write value
        address = 4'd12; writedata = 32'h55; read = 1'b1; write = 1'b1;
        step(1);
        read = 1'b0; write = 1'b0;
        chk("rw_same_cycle", readdata, 32'h0FFF_FFFF);
        do_read(4'd12, 32'h55, "rw_after");

        // NUM_CH=3 instance: channel 3 absent
        b_address = 4'd12; b_writedata = 32'h123; b_write = 1'b1;
        step(1);
        b_write = 1'b0; b_read = 1'b1;
        step(1);
        b_read = 1'b0;
        chk("nc3_ch3_valid", 32'(b_readdatavalid), 32'h1);
        chk("nc3_ch3_reload", b_readdata, 32'h0);
        b_address = 4'd8; b_read = 1'b1;
        step(1);
        b_read = 1'b0;
        chk("nc3_ch2_reload", b_readdata, 32'h0FFF_FFFF);
        b_address = 4'd1; b_read = 1'b1;
        step(1);
        b_read = 1'b0;
        chk("nc3_ch0_ctrl", b_readdata, 32'h0);
        chk("nc3_tick", 32'(b_tick), 32'h0);

        // ch1 continuous, period 4
        do_write(4'd4, 32'd3);
        do_write(4'd5, 32'h1);
        chk("ch1_tick_at_en", 32'(tick[1]), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk($sformatf("ch1_tick_c%0d", i), 32'(tick[1]), (i % 4 == 0) ? 32'h1 : 32'h0);
        end
        do_read(4'd6, 32'd3, "ch1_count_a");
        do_read(4'd6, 32'd2, "ch1_count_b");
        do_read(4'd6, 32'd1, "ch1_count_c");
        do_read(4'd6, 32'd0, "ch1_count_d");
        do_read(4'd6, 32'd3, "ch1_count_e");
        do_read(4'd5, 32'h5, "ch1_ctrl_flag");
        chk("ch1_no_irq", 32'(irq), 32'h0);

        // ch2 one-shot with interrupt
        do_write(4'd8, 32'd5);
        do_write(4'd9, 32'hB);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk($sformatf("ch2_tick_c%0d", i), 32'(tick[2]), (i == 6) ? 32'h1 : 32'h0);
            chk($sformatf("ch2_irq_c%0d", i), 32'(irq), (i >= 7) ? 32'h1 : 32'h0);
        end
        do_read(4'd9, 32'hE, "ch2_ctrl_done");
        do_read(4'd10, 32'd5, "ch2_count_done");
        do_write(4'd9, 32'h4);
        chk("ch2_irq_lag", 32'(irq), 32'h1);
        step(1);
        chk("ch2_irq_clr", 32'(irq), 32'h0);
        do_read(4'd9, 32'h0, "ch2_ctrl_clr");

        // ch0 RELOAD=0: tick constantly high, then reload 10 mid-run
        do_write(4'd0, 32'd0);
        do_write(4'd1, 32'h1);
        chk("ch0_tick_at_en", 32'(tick[0]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("ch0_tick_hi%0d", i), 32'(tick[0]), 32'h1);
        end
        do_write(4'd0, 32'd10);
        chk("ch0_reload_notick", 32'(tick[0]), 32'h0);
        do_read(4'd2, 32'd10, "ch0_count_reload");
        chk("ch0_tick_r1", 32'(tick[0]), 32'h0);
        for (int i = 2; i <= 12; i++) begin
            step(1);
            chk($sformatf("ch0_tick_r%0d", i), 32'(tick[0]), (i == 11) ? 32'h1 : 32'h0);
        end
        do_read(4'd1, 32'h5, "ch0_ctrl_w0flag");

        // Reset while ch1 counts with FLAG and IRQ_EN set, read in flight
        do_write(4'd5, 32'h9);
        chk("ch1_irq_pre", 32'(irq), 32'h0);
        step(1);
        chk("ch1_irq_on", 32'(irq), 32'h1);
        reset = 1'b1; address = 4'd5; read = 1'b1;
        step(1);
        reset = 1'b0; read = 1'b0;
        chk("rst2_rvalid", 32'(readdatavalid), 32'h0);
        chk("rst2_rdata", readdata, 32'h0);
        chk("rst2_tick", 32'(tick), 32'h0);
        chk("rst2_irq", 32'(irq), 32'h0);
        do_read(4'd5, 32'h0, "rst2_ch1_ctrl");
        do_read(4'd4, 32'h0FFF_FFFF, "rst2_ch1_reload");
        do_read(4'd6, 32'h0FFF_FFFF, "rst2_ch1_count");
        step(5);
        chk("rst2_tick_idle", 32'(tick), 32'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/custom_prescaler_bank.md
Name: custom_prescaler_bank

Overview:
- Multi-channel programmable prescaler; generalises the single 28-bit prescaler register into NUM_CH independent down-counters that each emit a one-cycle tick.
- Each channel has continuous or one-shot mode, a sticky tick flag and a maskable interrupt.
- Configured and observed over one Avalon-MM slave (avs_s0); ticks drive clock-enables of downstream peripherals (PWM, sampling, LED blink).

Parameters:
- NUM_CH, 4, number of channels (1..16).
- CNT_W, 28, counter and reload width in bits (1..32).
- ADDR_W, $clog2(NUM_CH)+2, derived; address = {channel, reg[1:0]}.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- avs_s0_address  input  ADDR_W  word address; [ADDR_W-1:2] is the channel, [1:0] is the register.
- avs_s0_read  input  1  read strobe.
- avs_s0_write  input  1  write strobe.
- avs_s0_writedata  input  32  write data.
- avs_s0_readdata  output  32  registered read data.
- avs_s0_readdatavalid  output  1  high one cycle after an accepted read.
- tick  output  NUM_CH  per-channel one-cycle pulse, registered.
- irq  output  1  OR over channels of (FLAG & IRQ_EN), registered.

Behaviour:
- Register map per channel:
  - 0 = RELOAD (rw, CNT_W bits).
  - 1 = CTRL: bit0 EN, bit1 ONESHOT, bit2 FLAG (write-1-to-clear), bit3 IRQ_EN.
  - 2 = COUNT (read-only).
  - 3 = reserved (reads 0, writes ignored).
- Reset values: RELOAD = all ones; COUNT = all ones; EN = ONESHOT = FLAG = IRQ_EN = 0; tick = 0; irq = 0; readdata = 0; readdatavalid = 0.
- Reads:
  - An accepted read captures the addressed value into readdata at the next edge and pulses readdatavalid; latency is 1 cycle.
  - Unused upper bits read as 0.
  - A channel index >= NUM_CH reads 0; writes to it are ignored.
  - When no read is accepted, readdatavalid = 0 and readdata holds its last value.
- Read and write asserted in the same cycle: both are performed. The read returns the pre-write value.
- Counter, per channel, evaluated at each clk edge with the current-cycle state:
  - EN = 1 and COUNT = 0: COUNT <= RELOAD, tick <= 1, FLAG <= 1. If ONESHOT = 1, EN <= 0.
  - EN = 1 and COUNT != 0: COUNT <= COUNT-1, tick <= 0.
  - EN = 0: COUNT holds, tick <= 0.
  - Tick period is RELOAD+1 cycles. RELOAD = 0 gives tick constantly high while enabled.
- A write to RELOAD also loads COUNT <= new value at the same edge, restarting the period. A reload write takes priority over a terminal-count event in the same cycle; no tick is generated in that cycle.
- A CTRL write with EN 0->1 loads COUNT <= RELOAD. With EN already 1, COUNT is untouched.
- A CTRL write of EN = 1 in the same cycle as a one-shot terminal count: the write wins, EN stays 1 and the tick still fires.
- FLAG: a hardware set and a W1C clear in the same cycle leaves the set winning (FLAG = 1). Writing 0 to bit2 has no effect.
- irq = |(FLAG & IRQ_EN), registered, so it follows FLAG by one cycle.
- Channels are fully independent; no cross-channel ordering.
- Reset mid-count forces all reset values at the next edge. Any in-flight read is dropped (readdatavalid = 0).

Test Plan:
- Reset, then read ch0 RELOAD and CTRL -> readdatavalid one cycle later; data 0x0FFFFFFF and 0x0 respectively; tick = 0, irq = 0.
- ch1 RELOAD = 3, CTRL = 0x1 -> tick[1] pulses every 4 cycles, first pulse 4 cycles after the EN write edge; COUNT reads 3,2,1,0 cycling.
- ch2 RELOAD = 5, CTRL = 0xB (EN, ONESHOT, IRQ_EN) -> exactly one tick[2] after 6 cycles; CTRL reads 0xE (EN cleared, FLAG set); irq = 1 one cycle after the FLAG edge. Write CTRL = 0x4 -> FLAG = 0, then irq = 0 next cycle.
- ch0 RELOAD = 0, EN = 1 -> tick[0] constantly 1. Rewrite RELOAD = 10 mid-run -> COUNT = 10 next edge and the next tick arrives 11 cycles later.
- NUM_CH = 3 build: write and read channel 3 -> read returns 0; channels 0..2 unaffected.
- Assert reset while ch1 is counting with FLAG set -> all registers return to reset values, tick and irq = 0 in the following cycle.
